// File: rtl/rs_flag_bank_if.sv
// Signal bundle for rs_flag_bank: per-channel set/clear/mode/mask inputs
// and the latched flag state with the combined request outputs.
interface rs_flag_bank_if #(
    parameter int CHANNELS = 4
);
    localparam int ID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] set_n;      // asynchronous, active-low set requests
    logic [CHANNELS-1:0] clr;        // synchronous clear pulses
    logic [CHANNELS-1:0] edge_mode;  // 1 = falling-edge set, 0 = level set
    logic [CHANNELS-1:0] mask;       // interrupt enables
    logic [CHANNELS-1:0] flags;      // latched flag state
    logic                irq_n;      // active-low combined request
    logic [ID_W-1:0]     first;      // lowest pending enabled channel

    modport master (
        output set_n, clr, edge_mode, mask,
        input  flags, irq_n, first
    );

    modport slave (
        input  set_n, clr, edge_mode, mask,
        output flags, irq_n, first
    );
endinterface

// File: rtl/rs_flag_bank.sv
// Bank of independent set/reset flags. Each set_n input is synchronised,
// turned into a level or falling-edge set event, and combined with a
// synchronous clear. Masked flags drive an active-low combined request and
// a lowest-index pending encoder.
module rs_flag_bank #(
    parameter int CHANNELS     = 4,
    parameter int SET_PRIORITY = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    rs_flag_bank_if.slave bus
);
    localparam int ID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Tracks how far real post-reset samples have travelled down the
    // synchroniser chains. Bit SYNC_STAGES-1 qualifies the sync stage and bit
    // SYNC_STAGES qualifies prev. The reset value 1 in the chains is not a real
    // observation of set_n high, so a set_n already low at reset release must
    // not look like a falling edge.
    logic [SYNC_STAGES:0] vld_reg;
    logic [CHANNELS-1:0]  flags_vec;
    logic [CHANNELS-1:0]  pend;
    logic [ID_W-1:0]      first_idx;

    // Validity shift register: fills with ones after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= {vld_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   flag_reg;
            logic                   flag_next;
            logic                   set_ev;
            logic                   sync_bit;

            assign sync_bit = sync_reg[SYNC_STAGES-1];

            // Synchroniser chain and previous-sample register; idle level is 1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '1;
                    prev_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.set_n[gi]};
                    prev_reg <= sync_bit;
                end
            end

            // Set event detection and set/clear resolution.
            always_comb begin
                set_ev    = 1'b0;
                flag_next = flag_reg;
                if (bus.edge_mode[gi]) begin
                    set_ev = vld_reg[SYNC_STAGES] & prev_reg & ~sync_bit;
                end else begin
                    set_ev = ~sync_bit;
                end
                if (set_ev && bus.clr[gi]) begin
                    flag_next = (SET_PRIORITY != 0);
                end else if (set_ev) begin
                    flag_next = 1'b1;
                end else if (bus.clr[gi]) begin
                    flag_next = 1'b0;
                end
            end

            // Flag state register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flag_reg <= 1'b0;
                end else begin
                    flag_reg <= flag_next;
                end
            end

            assign flags_vec[gi] = flag_reg;
        end
    endgenerate

    assign pend = flags_vec & bus.mask;

    // Lowest-index pending enabled channel; scanning downwards lets the
    // lowest index overwrite any higher one.
    always_comb begin
        first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                first_idx = ID_W'(i);
            end
        end
    end

    assign bus.flags = flags_vec;
    assign bus.irq_n = ~|pend;
    assign bus.first = first_idx;
endmodule

// File: tb/tb_rs_flag_bank.sv
// Testbench for rs_flag_bank: two instances (set-priority and clear-priority)
// share stimulus; expected {flags, irq_n, first} per cycle go through a
// scoreboard queue and are compared after each clock edge.
module tb_rs_flag_bank;
    typedef struct packed {
        logic [3:0] sn;
        logic [3:0] cl;
        logic [3:0] em;
        logic [3:0] mk;
        logic [3:0] f1;   // expected flags, SET_PRIORITY=1
        logic [3:0] f0;   // expected flags, SET_PRIORITY=0
    } step_t;

    typedef struct packed {
        logic [6:0] want1;
        logic [6:0] want0;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] set_n;
    logic [3:0] clr;
    logic [3:0] edge_mode;
    logic [3:0] mask;

    int n_checks = 0;
    int n_passed = 0;
    exp_t sb_q[$];

    rs_flag_bank_if #(.CHANNELS(4)) bus1 ();
    rs_flag_bank_if #(.CHANNELS(4)) bus0 ();

    assign bus1.set_n     = set_n;
    assign bus1.clr       = clr;
    assign bus1.edge_mode = edge_mode;
    assign bus1.mask      = mask;
    assign bus0.set_n     = set_n;
    assign bus0.clr       = clr;
    assign bus0.edge_mode = edge_mode;
    assign bus0.mask      = mask;

    rs_flag_bank #(.CHANNELS(4), .SET_PRIORITY(1), .SYNC_STAGES(2)) dut_sp1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    rs_flag_bank #(.CHANNELS(4), .SET_PRIORITY(0), .SYNC_STAGES(2)) dut_sp0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_first(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i[1:0];
        end
        return 2'd0;
    endfunction

    function automatic logic [6:0] want(input logic [3:0] f, input logic [3:0] mk);
        logic [3:0] p;
        p = f & mk;
        return {f, ~|p, exp_first(p)};
    endfunction

    function automatic step_t st(input logic [3:0] sn, input logic [3:0] cl,
                                 input logic [3:0] em, input logic [3:0] mk,
                                 input logic [3:0] f1, input logic [3:0] f0);
        step_t s;
        s.sn = sn; s.cl = cl; s.em = em; s.mk = mk; s.f1 = f1; s.f0 = f0;
        return s;
    endfunction

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic drive_step(input step_t s);
        exp_t e;
        set_n     = s.sn;
        clr       = s.cl;
        edge_mode = s.em;
        mask      = s.mk;
        e.want1   = want(s.f1, s.mk);
        e.want0   = want(s.f0, s.mk);
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        step_t seq[$];
        exp_t  e;
        rst_n = 1'b1; set_n = 4'hF; clr = 4'h0; edge_mode = 4'hF; mask = 4'hF;
        #1 rst_n = 1'b0;
        #1;
        e.want1 = want(4'h0, mask); e.want0 = want(4'h0, mask);
        sb_q.push_back(e);
        e = sb_q.pop_front();
        n_checks++;
        if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
            $display("FAIL reset_async sp1 {flags,irq_n,first} got %h want %h", {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
        else n_passed++;
        n_checks++;
        if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
            $display("FAIL reset_async sp0 {flags,irq_n,first} got %h want %h", {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
        else n_passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        foreach (seq[i]) begin
            drive_step(seq[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                $display("FAIL reset_idle step %0d sp1 got %h want %h", i, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
            else n_passed++;
            n_checks++;
            if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                $display("FAIL reset_idle step %0d sp0 got %h want %h", i, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
            else n_passed++;
        end
        $display("test_reset done, checks so far %0d", n_checks);
    endtask

    // set_n[2] low for 3 clocks in edge mode: flag two edges after first sample.
    task automatic test_edge_pulse();
        step_t seq[$];
        exp_t  e;
        seq.push_back(st(4'hB, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hB, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hB, 4'h0, 4'hF, 4'hF, 4'h4, 4'h4));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h4, 4'h4));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h4, 4'h4));
        seq.push_back(st(4'hF, 4'h4, 4'hF, 4'hF, 4'h0, 4'h0));
        foreach (seq[i]) begin
            drive_step(seq[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                $display("FAIL edge_pulse step %0d sp1 got %h want %h", i, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
            else n_passed++;
            n_checks++;
            if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                $display("FAIL edge_pulse step %0d sp0 got %h want %h", i, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
            else n_passed++;
        end
        $display("test_edge_pulse done, checks so far %0d", n_checks);
    endtask

    // Edge mode, set_n[0] held low: one event only; clear sticks until refall.
    task automatic test_edge_hold();
        step_t seq[$];
        exp_t  e;
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h1, 4'h1));
        seq.push_back(st(4'hE, 4'h1, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hE, 4'h0, 4'hF, 4'hF, 4'h1, 4'h1));
        seq.push_back(st(4'hF, 4'h1, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        foreach (seq[i]) begin
            drive_step(seq[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                $display("FAIL edge_hold step %0d sp1 got %h want %h", i, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
            else n_passed++;
            n_checks++;
            if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                $display("FAIL edge_hold step %0d sp0 got %h want %h", i, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
            else n_passed++;
        end
        $display("test_edge_hold done, checks so far %0d", n_checks);
    endtask

    // Level mode on channel 1 with clr coinciding, then a switch to edge mode
    // while set_n stays low, which must not create an event.
    task automatic test_level_priority();
        step_t seq[$];
        exp_t  e;
        seq.push_back(st(4'hD, 4'h0, 4'hD, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hD, 4'h0, 4'hD, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hD, 4'h0, 4'hD, 4'hF, 4'h2, 4'h2));
        seq.push_back(st(4'hD, 4'h2, 4'hD, 4'hF, 4'h2, 4'h0));
        seq.push_back(st(4'hD, 4'h0, 4'hD, 4'hF, 4'h2, 4'h2));
        seq.push_back(st(4'hD, 4'h2, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hD, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        foreach (seq[i]) begin
            drive_step(seq[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                $display("FAIL level_priority step %0d sp1 got %h want %h", i, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
            else n_passed++;
            n_checks++;
            if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                $display("FAIL level_priority step %0d sp0 got %h want %h", i, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
            else n_passed++;
        end
        $display("test_level_priority done, checks so far %0d", n_checks);
    endtask

    // Flags 0xA under several masks, then fill to 0xF with set_n settling high.
    task automatic test_mask_first();
        step_t seq[$];
        exp_t  e;
        seq.push_back(st(4'h5, 4'h0, 4'hF, 4'h8, 4'h0, 4'h0));
        seq.push_back(st(4'h5, 4'h0, 4'hF, 4'h8, 4'h0, 4'h0));
        seq.push_back(st(4'h5, 4'h0, 4'hF, 4'h8, 4'hA, 4'hA));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'h0, 4'hA, 4'hA));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'h2, 4'hA, 4'hA));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'hA, 4'hA));
        seq.push_back(st(4'hA, 4'h0, 4'hF, 4'hF, 4'hA, 4'hA));
        seq.push_back(st(4'hA, 4'h0, 4'hF, 4'hF, 4'hA, 4'hA));
        seq.push_back(st(4'hA, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF));
        foreach (seq[i]) begin
            drive_step(seq[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                $display("FAIL mask_first step %0d sp1 got %h want %h", i, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
            else n_passed++;
            n_checks++;
            if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                $display("FAIL mask_first step %0d sp0 got %h want %h", i, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
            else n_passed++;
        end
        $display("test_mask_first done, checks so far %0d", n_checks);
    endtask

    // Mid-operation resets: clears flags at once; afterwards a held-low set_n
    // sets a level channel (0) but never an edge channel (1).
    task automatic test_reset_mid();
        step_t seq[$];
        exp_t  e;
        for (int pass = 0; pass < 2; pass++) begin
            seq.delete();
            if (pass == 1) begin
                drive_step(st(4'hC, 4'h0, 4'hE, 4'hF, 4'h0, 4'h0));
                @(posedge clk); #1;
                e = sb_q.pop_front();
                n_checks++;
                if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                    $display("FAIL reset_mid pre sp1 got %h want %h", {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
                else n_passed++;
            end
            #3 rst_n = 1'b0;
            #1;
            e.want1 = want(4'h0, mask); e.want0 = want(4'h0, mask);
            sb_q.push_back(e);
            e = sb_q.pop_front();
            n_checks++;
            if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                $display("FAIL reset_mid_async pass %0d sp1 got %h want %h", pass, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
            else n_passed++;
            n_checks++;
            if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                $display("FAIL reset_mid_async pass %0d sp0 got %h want %h", pass, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
            else n_passed++;
            @(posedge clk); #1;
            rst_n = 1'b1;
            if (pass == 0) begin
                for (int i = 0; i < 4; i++) seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
            end else begin
                seq.push_back(st(4'hC, 4'h0, 4'hE, 4'hF, 4'h0, 4'h0));
                seq.push_back(st(4'hC, 4'h0, 4'hE, 4'hF, 4'h0, 4'h0));
                seq.push_back(st(4'hC, 4'h0, 4'hE, 4'hF, 4'h1, 4'h1));
                seq.push_back(st(4'hC, 4'h0, 4'hE, 4'hF, 4'h1, 4'h1));
                seq.push_back(st(4'hF, 4'h0, 4'hE, 4'hF, 4'h1, 4'h1));
                seq.push_back(st(4'hF, 4'h0, 4'hE, 4'hF, 4'h1, 4'h1));
                seq.push_back(st(4'hF, 4'h1, 4'hE, 4'hF, 4'h0, 4'h0));
                seq.push_back(st(4'hF, 4'h0, 4'hE, 4'hF, 4'h0, 4'h0));
            end
            foreach (seq[i]) begin
                drive_step(seq[i]);
                @(posedge clk); #1;
                e = sb_q.pop_front();
                n_checks++;
                if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                    $display("FAIL reset_mid pass %0d step %0d sp1 got %h want %h", pass, i, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
                else n_passed++;
                n_checks++;
                if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                    $display("FAIL reset_mid pass %0d step %0d sp0 got %h want %h", pass, i, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
                else n_passed++;
            end
        end
        $display("test_reset_mid done, checks so far %0d", n_checks);
    endtask

    // Channels 0 and 3 fall together and latch on the same edge.
    task automatic test_simultaneous();
        step_t seq[$];
        exp_t  e;
        seq.push_back(st(4'h6, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'h6, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0));
        seq.push_back(st(4'h6, 4'h0, 4'hF, 4'hF, 4'h9, 4'h9));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'h8, 4'h9, 4'h9));
        seq.push_back(st(4'hF, 4'h0, 4'hF, 4'hF, 4'h9, 4'h9));
        seq.push_back(st(4'hF, 4'h9, 4'hF, 4'hF, 4'h0, 4'h0));
        foreach (seq[i]) begin
            drive_step(seq[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus1.flags, bus1.irq_n, bus1.first} !== e.want1)
                $display("FAIL simultaneous step %0d sp1 got %h want %h", i, {bus1.flags, bus1.irq_n, bus1.first}, e.want1);
            else n_passed++;
            n_checks++;
            if ({bus0.flags, bus0.irq_n, bus0.first} !== e.want0)
                $display("FAIL simultaneous step %0d sp0 got %h want %h", i, {bus0.flags, bus0.irq_n, bus0.first}, e.want0);
            else n_passed++;
        end
        $display("test_simultaneous done, checks so far %0d", n_checks);
    endtask

    initial begin
        test_reset();
        test_edge_pulse();
        test_edge_hold();
        test_level_priority();
        test_mask_first();
        test_reset_mid();
        test_simultaneous();
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
        else n_passed++;
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
